// File: rtl/cfg_bus_pkg.sv
// Shared definitions for the configuration bus writer: pin mapping on ui_in,
// word count and the sequencing state encoding.
package cfg_bus_pkg;

    localparam int CFG_WORDS    = 8;
    localparam int STROBE_BIT   = 7;
    localparam int ADDR_LSB     = 1;
    localparam int BYTE_SEL_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_e;

    // Address field may be up to bits [6:1]; narrower addresses arrive zero-extended.
    function automatic logic [7:0] make_ctrl(input logic [5:0] addr,
                                             input logic       byte_sel,
                                             input logic       strobe);
        logic [7:0] ctrl;
        ctrl                   = '0;
        ctrl[ADDR_LSB +: 6]    = addr;
        ctrl[BYTE_SEL_BIT]     = byte_sel;
        ctrl[STROBE_BIT]       = strobe;
        return ctrl;
    endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Loadable down-counter shared by all bus phases; zero marks the last cycle
// of the current phase.
module cfg_phase_timer
    import cfg_bus_pkg::*;
#(
    parameter int CNT_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CNT_BITS-1:0] load_val,
    output logic                zero
);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cfg_bus_writer.sv
// Serialises 16-bit config word writes into strobed byte transfers on the
// synth's ui_in/uio_in pins, timed for a 2-flop strobe synchroniser.
//
//   state | meaning
//   IDLE  | strobe low, bus holds last byte, ready for a write
//   SETUP | byte, address and byte select driven, strobe low
//   HIGH  | strobe high, everything else held
//   LOW   | strobe low, everything else held; then next byte or done
module cfg_bus_writer
    import cfg_bus_pkg::*;
#(
    parameter int CEIL_LOG2_CFG_WORDS = $clog2(CFG_WORDS),
    parameter int SETUP_CYCLES        = 1,
    parameter int STROBE_HIGH_CYCLES  = 4,
    parameter int STROBE_LOW_CYCLES   = 4,
    parameter int CNT_BITS            = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [CEIL_LOG2_CFG_WORDS-1:0] wr_addr,
    input  logic [15:0]                    wr_data,
    input  logic [1:0]                     wr_be,
    output logic                           done,
    output logic [7:0]                     bus_data,
    output logic [7:0]                     bus_ctrl
);

    localparam logic [CNT_BITS-1:0] SETUP_LD = CNT_BITS'(SETUP_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] HIGH_LD  = CNT_BITS'(STROBE_HIGH_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] LOW_LD   = CNT_BITS'(STROBE_LOW_CYCLES - 1);

    state_e                           state_q, state_d;
    logic [CEIL_LOG2_CFG_WORDS-1:0]   addr_q, addr_d;
    logic [15:0]                      data_q, data_d;
    logic [1:0]                       be_q, be_d;
    logic                             sel_q, sel_d;
    logic [7:0]                       bus_data_q, bus_data_d;
    logic [7:0]                       bus_ctrl_q, bus_ctrl_d;
    logic                             done_q, done_d;

    logic                             tmr_load;
    logic [CNT_BITS-1:0]              tmr_val;
    logic                             tmr_zero;

    cfg_phase_timer #(
        .CNT_BITS (CNT_BITS)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        be_d       = be_q;
        sel_d      = sel_q;
        bus_data_d = bus_data_q;
        bus_ctrl_d = bus_ctrl_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    addr_d = wr_addr;
                    data_d = wr_data;
                    be_d   = wr_be;
                    if (wr_be == 2'b00) begin
                        done_d = 1'b1;
                    end else begin
                        // Low byte goes first whenever it is enabled.
                        sel_d      = ~wr_be[0];
                        state_d    = SETUP;
                        tmr_load   = 1'b1;
                        tmr_val    = SETUP_LD;
                        bus_data_d = sel_d ? wr_data[15:8] : wr_data[7:0];
                        bus_ctrl_d = make_ctrl(6'(wr_addr), sel_d, 1'b0);
                    end
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d                = HIGH;
                    tmr_load               = 1'b1;
                    tmr_val                = HIGH_LD;
                    bus_ctrl_d[STROBE_BIT] = 1'b1;
                end
            end
            HIGH: begin
                if (tmr_zero) begin
                    state_d                = LOW;
                    tmr_load               = 1'b1;
                    tmr_val                = LOW_LD;
                    bus_ctrl_d[STROBE_BIT] = 1'b0;
                end
            end
            LOW: begin
                if (tmr_zero) begin
                    if (!sel_q && be_q[1]) begin
                        sel_d      = 1'b1;
                        state_d    = SETUP;
                        tmr_load   = 1'b1;
                        tmr_val    = SETUP_LD;
                        bus_data_d = data_q[15:8];
                        bus_ctrl_d = make_ctrl(6'(addr_q), 1'b1, 1'b0);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            sel_q      <= 1'b0;
            bus_data_q <= '0;
            bus_ctrl_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
            sel_q      <= sel_d;
            bus_data_q <= bus_data_d;
            bus_ctrl_q <= bus_ctrl_d;
            done_q     <= done_d;
        end
    end

    assign wr_ready = (state_q == IDLE) && !reset;
    assign done     = done_q;
    assign bus_data = bus_data_q;
    assign bus_ctrl = bus_ctrl_q;

endmodule

// File: tb/tb_cfg_bus_writer.sv
// Directed bench for cfg_bus_writer: drives and samples on the falling edge,
// expectations are written out per cycle after the accepting rising edge.
module tb_cfg_bus_writer;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        done;
    logic [7:0]  bus_data;
    logic [7:0]  bus_ctrl;

    int errors = 0;
    int checks = 0;

    cfg_bus_writer dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .done     (done),
        .bus_data (bus_data),
        .bus_ctrl (bus_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_be    = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_in_reset: got %b want 0", wr_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_ctrl !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus_ctrl: got %h want 00", bus_ctrl);
        end
        checks++;
        if (bus_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus_data: got %h want 00", bus_data);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", wr_ready);
        end
    endtask

    // addr=3, data=12AB, be=01: one byte, ctrl 06 / 86 / 06, done at k=10.
    task automatic test_low_byte();
        logic [7:0] exp_ctrl;
        wr_valid = 1'b1;
        wr_addr  = 3'd3;
        wr_data  = 16'h12AB;
        wr_be    = 2'b01;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin
                wr_valid = 1'b0;
                wr_addr  = 3'd7;
                wr_data  = 16'hFFFF;
                wr_be    = 2'b11;
            end
            exp_ctrl = (k >= 2 && k <= 5) ? 8'h86 : 8'h06;
            checks++;
            if (bus_ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL low_ctrl k=%0d: got %h want %h", k, bus_ctrl, exp_ctrl);
            end
            checks++;
            if (bus_data !== 8'hAB) begin
                errors++;
                $display("FAIL low_data k=%0d: got %h want ab", k, bus_data);
            end
            checks++;
            if (done !== (k == 10)) begin
                errors++;
                $display("FAIL low_done k=%0d: got %b want %b", k, done, (k == 10));
            end
            checks++;
            if (wr_ready !== (k >= 10)) begin
                errors++;
                $display("FAIL low_ready k=%0d: got %b want %b", k, wr_ready, (k >= 10));
            end
        end
    endtask

    // addr=5, data=C35A, be=11: 5A with 0A/8A, then C3 with 0B/8B, done at k=19.
    task automatic test_both_bytes();
        logic [7:0] exp_ctrl;
        logic [7:0] exp_data;
        int         ph;
        wr_valid = 1'b1;
        wr_addr  = 3'd5;
        wr_data  = 16'hC35A;
        wr_be    = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                wr_valid = 1'b0;
                wr_data  = 16'h0000;
                wr_addr  = 3'd0;
            end
            ph       = (k - 1) % 9;
            exp_data = (k <= 9) ? 8'h5A : 8'hC3;
            exp_ctrl = (k <= 9) ? 8'h0A : 8'h0B;
            if (k <= 18 && ph >= 1 && ph <= 4) exp_ctrl = exp_ctrl | 8'h80;
            checks++;
            if (bus_ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL both_ctrl k=%0d: got %h want %h", k, bus_ctrl, exp_ctrl);
            end
            checks++;
            if (bus_data !== exp_data) begin
                errors++;
                $display("FAIL both_data k=%0d: got %h want %h", k, bus_data, exp_data);
            end
            checks++;
            if (done !== (k == 19)) begin
                errors++;
                $display("FAIL both_done k=%0d: got %b want %b", k, done, (k == 19));
            end
            checks++;
            if (wr_ready !== (k >= 19)) begin
                errors++;
                $display("FAIL both_ready k=%0d: got %b want %b", k, wr_ready, (k >= 19));
            end
        end
    endtask

    // be=00 after the C3/0B write: bus untouched, done one cycle after accept.
    task automatic test_be_zero();
        wr_valid = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 16'hFFFF;
        wr_be    = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) wr_valid = 1'b0;
            checks++;
            if (done !== (k == 1)) begin
                errors++;
                $display("FAIL be0_done k=%0d: got %b want %b", k, done, (k == 1));
            end
            checks++;
            if (wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL be0_ready k=%0d: got %b want 1", k, wr_ready);
            end
            checks++;
            if (bus_ctrl !== 8'h0B || bus_data !== 8'hC3) begin
                errors++;
                $display("FAIL be0_bus k=%0d: got ctrl=%h data=%h want ctrl=0b data=c3",
                         k, bus_ctrl, bus_data);
            end
        end
    endtask

    // addr=2, data=7E00, be=10: only the high byte, ctrl 05/85, done at k=10.
    task automatic test_high_only();
        logic [7:0] exp_ctrl;
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 16'h7E00;
        wr_be    = 2'b10;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) wr_valid = 1'b0;
            exp_ctrl = (k >= 2 && k <= 5) ? 8'h85 : 8'h05;
            checks++;
            if (bus_ctrl !== exp_ctrl || bus_data !== 8'h7E) begin
                errors++;
                $display("FAIL hi_bus k=%0d: got ctrl=%h data=%h want ctrl=%h data=7e",
                         k, bus_ctrl, bus_data, exp_ctrl);
            end
            checks++;
            if (done !== (k == 10)) begin
                errors++;
                $display("FAIL hi_done k=%0d: got %b want %b", k, done, (k == 10));
            end
        end
    endtask

    // A: addr=1 data=0011 be=01 (ctrl 02/82); B: addr=6 data=BB22 be=01 (ctrl 0C/8C).
    // wr_valid stays high, so B is accepted on the done cycle of A (k=10).
    task automatic test_back_to_back();
        logic [7:0] exp_ctrl;
        logic [7:0] exp_data;
        int         ph;
        int         low_run;
        int         rises;
        logic       prev_strobe;
        low_run     = 0;
        rises       = 0;
        prev_strobe = 1'b0;
        wr_valid    = 1'b1;
        wr_addr     = 3'd1;
        wr_data     = 16'h0011;
        wr_be       = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                wr_addr = 3'd6;
                wr_data = 16'hBB22;
                wr_be   = 2'b01;
            end
            if (k == 11) wr_valid = 1'b0;
            if (k <= 10) begin
                ph       = k - 1;
                exp_data = 8'h11;
                exp_ctrl = 8'h02;
            end else begin
                ph       = k - 11;
                exp_data = 8'h22;
                exp_ctrl = 8'h0C;
            end
            if (ph >= 1 && ph <= 4) exp_ctrl = exp_ctrl | 8'h80;
            checks++;
            if (bus_ctrl !== exp_ctrl || bus_data !== exp_data) begin
                errors++;
                $display("FAIL b2b_bus k=%0d: got ctrl=%h data=%h want ctrl=%h data=%h",
                         k, bus_ctrl, bus_data, exp_ctrl, exp_data);
            end
            checks++;
            if (done !== (k == 10 || k == 20)) begin
                errors++;
                $display("FAIL b2b_done k=%0d: got %b want %b", k, done, (k == 10 || k == 20));
            end
            if (bus_ctrl[7] && !prev_strobe) begin
                rises++;
                if (rises == 2) begin
                    checks++;
                    if (low_run < 4) begin
                        errors++;
                        $display("FAIL b2b_low_gap: got %0d cycles want >=4", low_run);
                    end
                end
                low_run = 0;
            end else if (!bus_ctrl[7]) begin
                low_run++;
            end
            prev_strobe = bus_ctrl[7];
        end
        checks++;
        if (rises != 2) begin
            errors++;
            $display("FAIL b2b_strobe_count: got %0d want 2", rises);
        end
    endtask

    // addr=4 data=00AA be=01: reset during the second HIGH cycle (k=3).
    task automatic test_reset_mid_high();
        int rises;
        rises    = 0;
        wr_valid = 1'b1;
        wr_addr  = 3'd4;
        wr_data  = 16'h00AA;
        wr_be    = 2'b01;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus_ctrl !== 8'h88) begin
            errors++;
            $display("FAIL rst_pre_ctrl: got %h want 88", bus_ctrl);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_ctrl !== 8'h00 || bus_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_bus: got ctrl=%h data=%h want 00/00", bus_ctrl, bus_data);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: got %b want 1", wr_ready);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_done: got %b want 0", done);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus_ctrl !== 8'h00 || done !== 1'b0) rises++;
        end
        checks++;
        if (rises != 0) begin
            errors++;
            $display("FAIL rst_no_retry: got %0d active cycles want 0", rises);
        end
    endtask

    initial begin
        test_reset();
        test_low_byte();
        test_both_bytes();
        test_be_zero();
        test_high_only();
        test_back_to_back();
        test_reset_mid_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
